// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and constants for the instruction fetch
//               sequencer: FSM state encoding, the NOP substituted for
//               out-of-range fetches, and the instruction width in bytes.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } fetch_state_e;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
    localparam int          INSTR_BYTES = 4;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/word_assembler.sv
`default_nettype none
// ============================================================================
// Module      : word_assembler
// Description : Four-lane byte register that builds a little-endian 32-bit
//               instruction word one byte at a time. Also accepts a whole
//               word load (used for NOP substitution) and a synchronous clear.
// Ports       : clk, rst_n      - clock, async active-low reset
//               i_clear         - zero all lanes (highest priority)
//               i_load_en       - load i_load_word into all lanes
//               i_wr_en         - write i_wr_byte into lane i_wr_lane
//               o_word          - assembled word {lane3,lane2,lane1,lane0}
// Revision    : 1.0 - initial release
// ============================================================================
module word_assembler
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_clear,
    input  logic        i_load_en,
    input  logic [31:0] i_load_word,
    input  logic        i_wr_en,
    input  logic [1:0]  i_wr_lane,
    input  logic [7:0]  i_wr_byte,
    output logic [31:0] o_word
);

    logic [INSTR_BYTES*8-1:0] r_word;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word <= '0;
        end else if (i_clear) begin
            r_word <= '0;
        end else if (i_load_en) begin
            r_word <= i_load_word;
        end else if (i_wr_en) begin
            for (int i = 0; i < INSTR_BYTES; i++) begin
                if (i_wr_lane == 2'(i)) begin
                    r_word[i*8 +: 8] <= i_wr_byte;
                end
            end
        end
    end

    assign o_word = r_word;

endmodule : word_assembler
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fetch_sequencer
// Description : Instruction fetch controller for a byte-wide instruction
//               memory. Reads four bytes (one per cycle) at the current PC,
//               assembles them little-endian and presents the word to decode
//               over a valid/ready handshake. Redirects take priority in any
//               state; fetches beyond the populated memory yield a NOP with
//               out_fault set.
// Ports       : clk, rst_n                  - clock, async active-low reset
//               mem_addr / mem_rdata        - byte-addressed memory port
//               redirect_valid/redirect_pc  - branch/jump target load
//               out_valid/out_ready         - handshake to decode
//               out_instr/out_pc/out_fault  - fetched word, its PC, NOP flag
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter int unsigned MEM_BYTES = 81
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [63:0] mem_addr,
    input  logic [7:0]  mem_rdata,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [63:0] out_pc,
    output logic        out_fault
);

    // Highest PC from which a full word still lies inside the memory.
    localparam logic [63:0] c_last_word_pc = 64'(MEM_BYTES) - 64'(INSTR_BYTES);

    fetch_state_e r_state, w_next_state;
    logic [63:0]  r_pc, w_next_pc;
    logic [1:0]   r_byte_idx, w_next_byte_idx;
    logic [63:0]  r_out_pc, w_next_out_pc;
    logic         r_out_fault, w_next_out_fault;

    logic         w_asm_clear;
    logic         w_asm_load;
    logic         w_asm_wr;
    logic         w_out_of_range;

    // Target is always word aligned; the low bits carry no information.
    logic         w_unused_redirect_lsbs;
    assign w_unused_redirect_lsbs = ^redirect_pc[1:0];

    assign w_out_of_range = (r_pc > c_last_word_pc);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= FETCH;
            r_pc        <= RESET_PC;
            r_byte_idx  <= 2'd0;
            r_out_pc    <= RESET_PC;
            r_out_fault <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_pc        <= w_next_pc;
            r_byte_idx  <= w_next_byte_idx;
            r_out_pc    <= w_next_out_pc;
            r_out_fault <= w_next_out_fault;
        end
    end

    always_comb begin
        w_next_state     = r_state;
        w_next_pc        = r_pc;
        w_next_byte_idx  = r_byte_idx;
        w_next_out_pc    = r_out_pc;
        w_next_out_fault = r_out_fault;
        w_asm_clear      = 1'b0;
        w_asm_load       = 1'b0;
        w_asm_wr         = 1'b0;

        case (r_state)
            FETCH: begin
                if ((r_byte_idx == 2'd0) && w_out_of_range) begin
                    // Skip the memory entirely and hand out a NOP.
                    w_next_state     = HOLD;
                    w_asm_load       = 1'b1;
                    w_next_out_pc    = r_pc;
                    w_next_out_fault = 1'b1;
                end else begin
                    w_asm_wr        = 1'b1;
                    w_next_byte_idx = 2'(r_byte_idx + 2'd1);
                    if (r_byte_idx == 2'd3) begin
                        w_next_state     = HOLD;
                        w_next_out_pc    = r_pc;
                        w_next_out_fault = 1'b0;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    w_next_state    = FETCH;
                    w_next_pc       = r_pc + 64'(INSTR_BYTES);
                    w_next_byte_idx = 2'd0;
                end
            end
            default: begin
                w_next_state = FETCH;
            end
        endcase

        // Redirect overrides everything above; a concurrent handshake has
        // already delivered its word, only the PC advance is replaced.
        if (redirect_valid) begin
            w_next_state    = FETCH;
            w_next_pc       = {redirect_pc[63:2], 2'b00};
            w_next_byte_idx = 2'd0;
            w_asm_clear     = 1'b1;
            w_asm_load      = 1'b0;
            w_asm_wr        = 1'b0;
        end
    end

    word_assembler u_word_assembler (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_clear     (w_asm_clear),
        .i_load_en   (w_asm_load),
        .i_load_word (NOP_INSTR),
        .i_wr_en     (w_asm_wr),
        .i_wr_lane   (r_byte_idx),
        .i_wr_byte   (mem_rdata),
        .o_word      (out_instr)
    );

    assign mem_addr  = r_pc + {62'd0, r_byte_idx};
    assign out_valid = (r_state == HOLD);
    assign out_pc    = r_out_pc;
    assign out_fault = r_out_fault;

endmodule : fetch_sequencer
`default_nettype wire
